uart_center_transmit: RTL and testbench

Transmit-side counterpart of the UART receive centre. It reads a byte buffer from word-addressed shared memory through an Avalon-MM read master. It then presents the bytes one at a time to the UART serializer using a rdy/ack handshake. The block sits between the memory-mapped control registers and the serial transmitter. It consumes buffers in the same little-endian packed format that the receive centre writes: byte lane 0 is readdata[7:0].

---
 rtl/uart_center_transmit.sv | 149 ++++++++++++++
 tb/tb_uart_center_transmit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_center_transmit.sv
// uart_center_transmit
//   Reads a little-endian packed byte buffer from word-addressed memory over
//   an Avalon-MM read master and hands the bytes one at a time to the UART
//   serializer through a rdy/ack handshake. Each memory word is fetched once
//   and reused for every byte lane the transfer touches in it.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   control_trans_enable        level: high runs a transfer, low aborts to IDLE
//   control_trans_start_addr    byte address of the first byte (sampled in LOAD)
//   control_trans_len           byte count (sampled in LOAD)
//   control_trans_work          high from LOAD through DONE
//   control_trans_done          one-cycle pulse at the end of a transfer
//   trans_char / trans_rdy      byte to serializer and its valid
//   trans_ack                   serializer accepted trans_char
//   avm_m1_*                    Avalon-MM read master (32-bit data)
module uart_center_transmit #(
  parameter int ADDR_WIDTH = 16,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  control_trans_enable,
  input  logic [ADDR_WIDTH-1:0] control_trans_start_addr,
  input  logic [LEN_WIDTH-1:0]  control_trans_len,
  output logic                  control_trans_work,
  output logic                  control_trans_done,
  output logic [7:0]            trans_char,
  output logic                  trans_rdy,
  input  logic                  trans_ack,
  output logic                  avm_m1_read,
  output logic [ADDR_WIDTH-1:0] avm_m1_address,
  input  logic                  avm_m1_waitrequest,
  input  logic                  avm_m1_readdatavalid,
  input  logic [31:0]           avm_m1_readdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_READ_W, S_SEND, S_NEXT, S_DONE, S_HOLD
  } state_t;

  state_t                r_state, w_state_nx;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nx, w_addr_inc;
  logic [LEN_WIDTH-1:0]  r_cnt, w_cnt_nx;
  logic [31:0]           r_word, w_word_nx;
  logic [7:0]            r_char, w_char_nx;
  logic                  r_rdy, w_rdy_nx;

  // Byte lane 0 is the least significant byte of the word.
  function automatic logic [7:0] lane_sel(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

  // Address increment wraps naturally modulo 2^ADDR_WIDTH.
  assign w_addr_inc = r_addr + ADDR_WIDTH'(1);

  // Next-state / next-data decode
  always_comb begin
    w_state_nx = r_state;
    w_addr_nx  = r_addr;
    w_cnt_nx   = r_cnt;
    w_word_nx  = r_word;
    w_char_nx  = r_char;
    w_rdy_nx   = r_rdy;
    if (!control_trans_enable) begin
      // Abort from anywhere; a late readdatavalid then lands in IDLE and is ignored.
      w_state_nx = S_IDLE;
      w_rdy_nx   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_LOAD;
        S_LOAD: begin
          w_addr_nx  = control_trans_start_addr;
          w_cnt_nx   = control_trans_len;
          w_state_nx = (control_trans_len == '0) ? S_DONE : S_READ;
        end
        S_READ: begin
          if (!avm_m1_waitrequest) w_state_nx = S_READ_W;
        end
        S_READ_W: begin
          if (avm_m1_readdatavalid) begin
            w_word_nx  = avm_m1_readdata;
            w_char_nx  = lane_sel(avm_m1_readdata, r_addr[1:0]);
            w_rdy_nx   = 1'b1;
            w_state_nx = S_SEND;
          end
        end
        S_SEND: begin
          if (r_rdy && trans_ack) begin
            w_rdy_nx = 1'b0;
            if (r_cnt != '0) w_cnt_nx = r_cnt - LEN_WIDTH'(1);
            w_state_nx = S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_cnt == '0) begin
            w_state_nx = S_DONE;
          end else begin
            w_addr_nx = w_addr_inc;
            if (w_addr_inc[1:0] == 2'd0) begin
              // Crossed into a new word: refetch.
              w_state_nx = S_READ;
            end else begin
              w_char_nx  = lane_sel(r_word, w_addr_inc[1:0]);
              w_rdy_nx   = 1'b1;
              w_state_nx = S_SEND;
            end
          end
        end
        S_DONE: w_state_nx = S_HOLD;
        S_HOLD: w_state_nx = S_HOLD;
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_char  <= '0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_addr  <= w_addr_nx;
      r_cnt   <= w_cnt_nx;
      r_word  <= w_word_nx;
      r_char  <= w_char_nx;
      r_rdy   <= w_rdy_nx;
    end
  end

  // Outputs decoded from registered state only, so nothing glitches during reset.
  assign avm_m1_read        = (r_state == S_READ);
  assign avm_m1_address     = avm_m1_read ? {r_addr[ADDR_WIDTH-1:2], 2'b00} : '0;
  assign control_trans_work = r_state inside {S_LOAD, S_READ, S_READ_W, S_SEND, S_NEXT, S_DONE};
  assign control_trans_done = (r_state == S_DONE);
  assign trans_rdy          = r_rdy;
  assign trans_char         = r_char;

endmodule

// File: tb/tb_uart_center_transmit.sv
module tb_uart_center_transmit;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [15:0] start_addr;
  logic [15:0] len;
  logic        work, done;
  logic [7:0]  tchar;
  logic        trdy, tack;
  logic        rd;
  logic [15:0] addr;
  logic        wr, rdv;
  logic [31:0] rdata;

  uart_center_transmit #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .control_trans_enable     (enable),
    .control_trans_start_addr (start_addr),
    .control_trans_len        (len),
    .control_trans_work       (work),
    .control_trans_done       (done),
    .trans_char               (tchar),
    .trans_rdy                (trdy),
    .trans_ack                (tack),
    .avm_m1_read              (rd),
    .avm_m1_address           (addr),
    .avm_m1_waitrequest       (wr),
    .avm_m1_readdatavalid     (rdv),
    .avm_m1_readdata          (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard queues and memory image
  logic [7:0]  exp_char_q[$];
  logic [15:0] exp_addr_q[$];
  logic [31:0] mem [int];

  // Bench controls
  bit ack_en, lat_chk, spur_ack;
  int ack_dly, lat_cfg, stall_left;

  // Monitor counters
  int n_done, n_reads, n_chars, n_rdy_cyc, n_stall, n_rdv;

  // Slave / serializer model state
  bit          rsp_pend, stalled_prev, rdv_prev;
  int          rsp_dly, rdy_age;
  logic [31:0] rsp_data;
  logic [15:0] stall_addr;

  // Avalon slave, serializer ack model and monitors; all act on the falling edge.
  initial begin
    wr = 0; rdv = 0; rdata = 0; tack = 0;
    rsp_pend = 0; stalled_prev = 0; rdv_prev = 0; rdy_age = 0;
    rsp_dly = 0; rsp_data = 0; stall_addr = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        wr = 0; rdv = 0; tack = 0;
        rsp_pend = 0; stalled_prev = 0; rdv_prev = 0; rdy_age = 0;
      end else begin
        bit sp;
        if (done) n_done++;
        if (trdy) n_rdy_cyc++;
        if (rdv_prev && lat_chk) chk("rdy_after_rdv", 32'(trdy), 1);
        rdv_prev = 0;
        // response channel
        rdv = 0;
        if (rsp_pend) begin
          if (rsp_dly == 0) begin
            rdv = 1; rdata = rsp_data; rsp_pend = 0; rdv_prev = 1; n_rdv++;
            if (lat_chk) chk("rdy_before_rdv", 32'(trdy), 0);
          end else begin
            rsp_dly--;
          end
        end
        // command channel
        sp = stalled_prev;
        if (sp) begin
          chk("stall_read_hold", 32'(rd), 1);
          chk("stall_addr_hold", 32'(addr), 32'(stall_addr));
        end
        stalled_prev = 0;
        wr = 0;
        if (rd) begin
          if (stall_left > 0) begin
            wr = 1; stall_left--; stalled_prev = 1; n_stall++;
            if (!sp) stall_addr = addr;
          end else begin
            n_reads++;
            if (exp_addr_q.size() == 0) chk("read_unexpected", 32'(exp_addr_q.size()), 1);
            else chk("read_addr", 32'(addr), 32'(exp_addr_q.pop_front()));
            rsp_pend = 1;
            rsp_dly  = lat_cfg;
            rsp_data = mem.exists(int'(addr)) ? mem[int'(addr)] : 32'h0;
          end
        end
        // serializer
        tack = 0;
        if (trdy && ack_en) begin
          if (exp_char_q.size() == 0) chk("char_unexpected", 32'(exp_char_q.size()), 1);
          else chk("char", 32'(tchar), 32'(exp_char_q[0]));
          if (rdy_age == ack_dly) begin
            tack = 1; rdy_age = 0; n_chars++;
            if (exp_char_q.size() != 0) void'(exp_char_q.pop_front());
          end else begin
            rdy_age++;
          end
        end else begin
          rdy_age = 0;
          if (spur_ack && !trdy) tack = 1;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic clr_counts();
    n_done = 0; n_reads = 0; n_chars = 0; n_rdy_cyc = 0; n_stall = 0; n_rdv = 0;
  endtask

  task automatic wait_done(input int lim);
    int k = 0;
    while (n_done == 0 && k < lim) begin tick(1); k++; end
    chk("done_timeout", 32'(n_done != 0), 1);
  endtask

  task automatic wait_rdy(input int lim);
    int k = 0;
    while (!trdy && k < lim) begin tick(1); k++; end
    chk("rdy_timeout", 32'(trdy), 1);
  endtask

  task automatic wait_reads(input int n, input int lim);
    int k = 0;
    while (n_reads < n && k < lim) begin tick(1); k++; end
    chk("read_timeout", 32'(n_reads), 32'(n));
  endtask

  task automatic start(input logic [15:0] a, input logic [15:0] l);
    clr_counts();
    start_addr = a; len = l; enable = 1;
  endtask

  task automatic finish_xfer(input string t, input int reads, input int chars);
    tick(2);
    chk({t, "_work_after"}, 32'(work), 0);
    chk({t, "_done_cycles"}, 32'(n_done), 1);
    chk({t, "_reads"}, 32'(n_reads), 32'(reads));
    chk({t, "_chars"}, 32'(n_chars), 32'(chars));
    chk({t, "_char_q_left"}, 32'(exp_char_q.size()), 0);
    enable = 0;
    tick(2);
  endtask

  task automatic check_all_zero(input string t);
    chk({t, "_rdy"}, 32'(trdy), 0);
    chk({t, "_char"}, 32'(tchar), 0);
    chk({t, "_read"}, 32'(rd), 0);
    chk({t, "_addr"}, 32'(addr), 0);
    chk({t, "_work"}, 32'(work), 0);
    chk({t, "_done"}, 32'(done), 0);
  endtask

  initial begin
    rst = 0; enable = 0; start_addr = 0; len = 0;
    ack_en = 1; ack_dly = 2; lat_cfg = 0; lat_chk = 1; stall_left = 0; spur_ack = 0;
    clr_counts();
    tick(2);
    check_all_zero("reset");
    rst = 1;
    tick(1);

    // 1: aligned send
    mem[32'h10] = 32'h44434241;
    exp_char_q = '{8'h41, 8'h42, 8'h43, 8'h44};
    exp_addr_q = '{16'h0010};
    start(16'h0010, 16'd4);
    wait_done(200);
    finish_xfer("t1", 1, 4);

    // 2: unaligned start crossing a word, spurious acks while not ready
    mem[32'h10] = 32'hAA000000;
    mem[32'h14] = 32'h0000CCBB;
    exp_char_q = '{8'hAA, 8'hBB, 8'hCC};
    exp_addr_q = '{16'h0010, 16'h0014};
    spur_ack = 1;
    start(16'h0013, 16'd3);
    wait_done(200);
    spur_ack = 0;
    finish_xfer("t2", 2, 3);

    // 3: waitrequest stall and read latency
    mem[32'h20] = 32'h04030201;
    exp_char_q = '{8'h01};
    exp_addr_q = '{16'h0020};
    stall_left = 5; lat_cfg = 2;
    start(16'h0020, 16'd1);
    wait_done(200);
    chk("t3_stall_cycles", 32'(n_stall), 5);
    finish_xfer("t3", 1, 1);
    lat_cfg = 0;

    // 4A: zero length
    start(16'h0050, 16'd0);
    wait_done(50);
    chk("t4a_rdy_cycles", 32'(n_rdy_cyc), 0);
    finish_xfer("t4a", 0, 0);

    // 4B: address wrap
    mem[32'hFFFC] = 32'h44332211;
    mem[32'h0000] = 32'h88776655;
    exp_char_q = '{8'h33, 8'h44, 8'h55, 8'h66};
    exp_addr_q = '{16'hFFFC, 16'h0000};
    start(16'hFFFE, 16'd4);
    wait_done(300);
    finish_xfer("t4b", 2, 4);

    // 5: abort while ready and un-acked
    mem[32'h30] = 32'h0D0C0B0A;
    ack_en = 0;
    exp_addr_q = '{16'h0030};
    start(16'h0030, 16'd4);
    wait_rdy(100);
    enable = 0;
    tick(1);
    chk("t5_abort_rdy", 32'(trdy), 0);
    chk("t5_abort_read", 32'(rd), 0);
    chk("t5_abort_work", 32'(work), 0);
    tick(3);
    chk("t5_abort_no_done", 32'(n_done), 0);
    // second abort during READ_W with late data
    lat_chk = 0; lat_cfg = 6;
    exp_addr_q = '{16'h0030};
    start(16'h0030, 16'd4);
    wait_reads(1, 100);
    tick(1);
    enable = 0;
    tick(12);
    chk("t5_late_rdv_sent", 32'(n_rdv), 1);
    chk("t5_late_rdy_cycles", 32'(n_rdy_cyc), 0);
    chk("t5_late_no_done", 32'(n_done), 0);
    chk("t5_late_work", 32'(work), 0);
    // clean restart
    lat_chk = 1; lat_cfg = 0; ack_en = 1;
    exp_char_q = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    exp_addr_q = '{16'h0030};
    start(16'h0030, 16'd4);
    wait_done(300);
    finish_xfer("t5_restart", 1, 4);

    // 6: asynchronous reset mid-SEND
    mem[32'h40] = 32'h0000BEEF;
    ack_en = 0;
    exp_addr_q = '{16'h0040};
    start(16'h0040, 16'd2);
    wait_rdy(100);
    rst = 0;
    #1;
    check_all_zero("t6_async");
    enable = 0;
    tick(2);
    rst = 1;
    tick(2);
    chk("t6_idle_work", 32'(work), 0);
    chk("t6_idle_rdy", 32'(trdy), 0);
    ack_en = 1;
    exp_char_q = '{8'hEF, 8'hBE};
    exp_addr_q = '{16'h0040};
    start(16'h0040, 16'd2);
    wait_done(200);
    finish_xfer("t6_restart", 1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
